// File: rtl/dcache_ctrl.sv
//==============================================================================
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache of
// one-word lines. Optional hit/miss counters are enabled by DCACHE_STATS_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int c_IW = $clog2(LINES);
  localparam int c_TW = 30 - c_IW;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_mask;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [LINES-1:0]  r_valid;
  logic [c_TW-1:0]   r_tag  [LINES];
  logic [31:0]       r_data [LINES];

  logic [c_IW-1:0]   w_idx_req, w_idx_r;
  logic              w_hit_req, w_hit_r, w_hs;

  assign w_idx_req = req_addr[c_IW+1:2];
  assign w_idx_r   = r_addr[c_IW+1:2];
  assign w_hit_req = r_valid[w_idx_req] && (r_tag[w_idx_req] == req_addr[31:c_IW+2]);
  assign w_hit_r   = r_valid[w_idx_r] && (r_tag[w_idx_r] == r_addr[31:c_IW+2]);
  assign w_hs      = req_valid && req_ready;

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] mask,
                                         input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (mask)
      3'b000:  f_load = {{24{b[7]}}, b};
      3'b001:  f_load = {{16{h[15]}}, h};
      3'b010:  f_load = word;
      3'b100:  f_load = {24'd0, b};
      3'b101:  f_load = {16'd0, h};
      default: f_load = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [2:0] mask, input logic [1:0] off);
    f_merge = word;
    case (mask[1:0])
      2'b00:   f_merge[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   f_merge[{off[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   f_merge = wd;
      default: f_merge = word;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_mask    = 3'b000;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_we)         w_state_nxt = S_WRITE;
          else if (w_hit_req) w_state_nxt = S_RESP;
          else                w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        mem_rd_en   = 1'b1;
        mem_mask    = 3'b010;
        mem_addr    = {r_addr[31:2], 2'b00};
        w_state_nxt = S_RESP;
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_mask    = r_mask;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mask  <= 3'b000;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_mask  <= req_mask;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= (!req_we && w_hit_req) ?
                   f_load(r_data[w_idx_req], req_mask, req_addr[1:0]) : 32'd0;
      end
      if (r_state == S_FILL) begin
        r_rdata          <= f_load(mem_rdata, r_mask, r_addr[1:0]);
        r_valid[w_idx_r] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL) begin
      r_tag[w_idx_r]  <= r_addr[31:c_IW+2];
      r_data[w_idx_r] <= mem_rdata;
    end else if (r_state == S_WRITE && w_hit_r) begin
      r_data[w_idx_r] <= f_merge(r_data[w_idx_r], r_wdata, r_mask, r_addr[1:0]);
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (w_hs && !req_we) begin
      if (w_hit_req) hit_count  <= hit_count + 32'd1;
      else           miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of direct-mapped one-word lines (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  single system clock, all state updated on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core load/store request present.
REQ-005 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_mask  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  load result, extended per mask; 0 for stores.
REQ-012 SHALL have ports mem_addr output 32, mem_wdata output 32, mem_mask output 3, mem_wr_en output 1, mem_rd_en output 1, mem_rdata input 32, connecting directly to the downstream data memory (combinational read, write on clk edge).

Function
REQ-013 SHALL split req_addr as offset [1:0], index [log2(LINES)+1:2], tag [31:log2(LINES)+2]; each line holds valid, tag, 32-bit word.
REQ-014 SHALL implement FSM IDLE, FILL, WRITE, RESP; req_ready = 1 only in IDLE; handshake = req_valid & req_ready; request fields registered at handshake.
REQ-015 IDLE, load hit (valid & tag match): SHALL go to RESP; resp_valid asserted the next cycle (latency 1).
REQ-016 IDLE, load miss: SHALL go to FILL; FILL drives mem_rd_en=1, mem_mask=010, mem_addr={addr[31:2],2'b00} for exactly one cycle, writes mem_rdata into the line (valid=1, new tag), then RESP (latency 2).
REQ-017 IDLE, store: SHALL go to WRITE; WRITE drives mem_wr_en=1 with registered addr, mask, wdata unmodified for exactly one cycle (write-through, no write-allocate), then RESP (latency 2).
REQ-018 Store hit SHALL merge the byte/halfword/word into the cached word in WRITE using addr[1:0]; store miss SHALL leave the array unchanged.
REQ-019 RESP SHALL assert resp_valid for one cycle and return to IDLE; a new request may be accepted the cycle after RESP.
REQ-020 Load result SHALL select byte addr[1:0] or halfword addr[1] from the cached/filled word, sign-extend for 000/001, zero-extend for 100/101, pass word for 010; undefined masks return 0.
REQ-021 mem_rd_en and mem_wr_en SHALL never be asserted together and SHALL be 0 outside FILL/WRITE; mem_addr/wdata/mask SHALL be 0 in IDLE and RESP.
REQ-022 Misaligned accesses SHALL not be checked; the word at addr[31:2] is used.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, clear all valid bits, resp_valid=0, resp_rdata=0, mem_wr_en=0, mem_rd_en=0; req_ready=1 after release.
REQ-024 Reset asserted during FILL or WRITE SHALL abort the transaction with no response and no cache update.

Configuration
REQ-025 With DCACHE_STATS_EN defined, SHALL add outputs hit_count 32 and miss_count 32, reset to 0, incremented once per accepted load hit / load miss, wrapping at 2^32; without it, ports and counters absent and behaviour otherwise identical.

Verification
REQ-026 After reset, load W 0x40 (memory 0x11223344) -> FILL one cycle, resp_rdata=0x11223344 two cycles after handshake; repeat -> hit, latency 1, no mem_rd_en.
REQ-027 Load B 0x43 with word 0x80FF0000 cached -> 0xFFFFFF80; load BU 0x43 -> 0x00000080; load HU 0x42 -> 0x000080FF.
REQ-028 Store B 0xAB to 0x41 on cached word 0x11223344 -> mem_wr_en one cycle, mask 000; following load W 0x40 hits, returns 0x1122AB44.
REQ-029 Store miss to 0x80, then load W 0x80 -> FILL issued (no allocate on store), data from memory.
REQ-030 LINES=16: load 0x00 then 0x40 (same index, new tag) -> both miss; load 0x00 again -> miss (evicted); reset_n pulsed mid-FILL -> no resp_valid, next load 0x40 misses.
REQ-031 With DCACHE_STATS_EN: sequence of REQ-026 -> hit_count=1, miss_count=1.
